// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register: operation modes,
// control FSM states and the shift-count width helper.
package usr_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_LOADED   = 2'd1,
    ST_SHIFTING = 2'd2,
    ST_SHIFTED  = 2'd3
  } usr_state_e;

  // Bits needed to hold a shift count of 0..w without wrapping.
  function automatic int cnt_bits(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/usr_bit_cell.sv
// One storage bit of the universal shift register: a 4:1 next-value mux
// selected by mode, plus true and complemented outputs.
module usr_bit_cell
  import usr_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic [1:0] mode,
  input  logic       shr_in,
  input  logic       shl_in,
  input  logic       ld_in,
  output logic       q,
  output logic       q_bar
);

  logic nxt;

  // Next-value select: hold, take left neighbour, take right neighbour, load.
  always_comb begin
    nxt = q;
    case (mode)
      MODE_HOLD: nxt = q;
      MODE_SHR:  nxt = shr_in;
      MODE_SHL:  nxt = shl_in;
      MODE_LOAD: nxt = ld_in;
      default:   nxt = q;
    endcase
  end

  // Storage bit with synchronous active-low clear overriding the mux.
  always_ff @(posedge clk) begin
    if (!clr) q <= 1'b0;
    else      q <= nxt;
  end

  assign q_bar = ~q;

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold / shift right / shift left / parallel load,
// with a control FSM that pulses done on the WIDTH-th shift after a load.
// Optional build macro USR_ROTATE_EN adds a rot input turning shifts into
// rotates (serial inputs ignored while rot=1).
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d_in,
  input  logic             sin_r,
  input  logic             sin_l,
`ifdef USR_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] q_1,
  output logic [WIDTH-1:0] q_bar_1,
  output logic             sout,
  output logic             done,
  output logic             busy
);

  localparam int CW = cnt_bits(WIDTH);

  logic             ser_r;
  logic             ser_l;
  logic [WIDTH-1:0] shr_vec;
  logic [WIDTH-1:0] shl_vec;
  usr_state_e       state;
  logic [CW-1:0]    cnt;

`ifdef USR_ROTATE_EN
  // Rotate recirculates the bit falling off the opposite end.
  assign ser_r = rot ? q_1[0]       : sin_r;
  assign ser_l = rot ? q_1[WIDTH-1] : sin_l;
`else
  assign ser_r = sin_r;
  assign ser_l = sin_l;
`endif

  // Per-bit shift sources: bit i takes bit i+1 on a right shift, bit i-1 on a left.
  assign shr_vec = {ser_r, q_1[WIDTH-1:1]};
  assign shl_vec = {q_1[WIDTH-2:0], ser_l};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    usr_bit_cell u_cell (
      .clk    (clk),
      .clr    (clr),
      .mode   (mode),
      .shr_in (shr_vec[i]),
      .shl_in (shl_vec[i]),
      .ld_in  (d_in[i]),
      .q      (q_1[i]),
      .q_bar  (q_bar_1[i])
    );
  end

  // Serial output: the bit pushed off the end by the last shift, zeroed by load.
  always_ff @(posedge clk) begin
    if (!clr) begin
      sout <= 1'b0;
    end else begin
      case (mode)
        MODE_SHR:  sout <= q_1[0];
        MODE_SHL:  sout <= q_1[WIDTH-1];
        MODE_LOAD: sout <= 1'b0;
        default:   sout <= sout;
      endcase
    end
  end

  // Control FSM: counts shifts since the last load, pulses done on the
  // WIDTH-th one; count saturates at WIDTH because SHIFTED stops counting.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state <= ST_EMPTY;
      cnt   <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (mode)
        MODE_LOAD: begin
          state <= ST_LOADED;
          cnt   <= '0;
          busy  <= 1'b0;
        end
        MODE_SHR, MODE_SHL: begin
          if (state == ST_LOADED || state == ST_SHIFTING) begin
            cnt <= cnt + 1'b1;
            if (state == ST_SHIFTING && cnt == CW'(WIDTH - 1)) begin
              state <= ST_SHIFTED;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= ST_SHIFTING;
              busy  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 4, register width in bits (legal range 2..16).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port clr, input, 1, synchronous active-low reset.
REQ-004 SHALL have port mode, input, 2, operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-005 SHALL have port d_in, input, WIDTH, parallel load data.
REQ-006 SHALL have port sin_r, input, 1, serial bit entering the MSB on a shift right.
REQ-007 SHALL have port sin_l, input, 1, serial bit entering the LSB on a shift left.
REQ-008 SHALL have port q_1, output, WIDTH, register contents.
REQ-009 SHALL have port q_bar_1, output, WIDTH, bitwise complement of q_1 at all times.
REQ-010 SHALL have port sout, output, 1, bit most recently shifted out; 0 after reset and after a load.
REQ-011 SHALL have port done, output, 1, one-cycle pulse when the WIDTH-th shift since the last load completes.
REQ-012 SHALL have port busy, output, 1, high while in state SHIFTING.

Function
REQ-013 Shift right SHALL give q_1 <= {sin_r, q_1[WIDTH-1:1]} and sout <= old q_1[0].
REQ-014 Shift left SHALL give q_1 <= {q_1[WIDTH-2:0], sin_l} and sout <= old q_1[WIDTH-1].
REQ-015 Parallel load SHALL give q_1 <= d_in and sout <= 0, with one-cycle latency.
REQ-016 Hold SHALL leave q_1, sout and the shift count unchanged.
REQ-017 Control FSM SHALL have states EMPTY, LOADED, SHIFTING, SHIFTED.
REQ-018 Transitions: any state + load -> LOADED with count cleared; LOADED/SHIFTING + shift -> SHIFTING with count+1; SHIFTING + shift with count = WIDTH-1 -> SHIFTED and done=1 for that cycle.
REQ-019 Shifts in EMPTY or SHIFTED SHALL update q_1/sout but neither change state nor count nor assert done.
REQ-020 Count SHALL be ceil(log2(WIDTH+1)) bits and SHALL never wrap; mixed left/right shifts each count as one.
REQ-021 Load in the same cycle as the completing shift SHALL win: state LOADED, done=0.
REQ-022 done SHALL be registered, asserted exactly one cycle, never two consecutive cycles.

Reset
REQ-023 clr=0 at a rising edge SHALL set q_1=0, q_bar_1=all ones, sout=0, done=0, busy=0, count=0, state EMPTY, overriding mode.
REQ-024 Reset mid-shift SHALL discard the partial count; the next load restarts normally.

Configuration
REQ-025 Macro USR_ROTATE_EN SHALL, when defined, add input port rot (1 bit); with rot=1 shift right feeds old q_1[0] into the MSB and shift left feeds old q_1[WIDTH-1] into the LSB, ignoring sin_r/sin_l; FSM and done behaviour unchanged.
REQ-026 Without USR_ROTATE_EN, port rot SHALL be absent and shifts SHALL always use sin_r/sin_l.

Structure
REQ-027 Package usr_pkg SHALL hold the mode encodings (MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD) and the FSM state encoding.
REQ-028 Sub-module usr_bit_cell (one storage bit plus 4:1 next-value mux, q and q_bar outputs) SHALL be instantiated WIDTH times.

Verification (WIDTH=4)
REQ-029 Reset, then load 1011 -> q_1=1011, q_bar_1=0100, sout=0, state LOADED, done=0.
REQ-030 Load 1011, four shift-right cycles with sin_r=0 -> q_1 1011->0101->0010->0001->0000; sout 1,1,0,1; done=1 only on the 4th cycle.
REQ-031 Load 0001, shift left with sin_l=1 twice, hold 3 cycles, shift left twice -> q_1=0111 then 1111; done on the 4th shift only.
REQ-032 Load 1100, three shifts, then load 0011 and shift in the same cycle as would complete -> q_1=0011, done=0, state LOADED.
REQ-033 Load 1010, two shifts, clr=0 for one cycle -> q_1=0000, busy=0, state EMPTY; four further shifts produce no done.
REQ-034 With USR_ROTATE_EN and rot=1, load 1000, four shift-right cycles -> 0100, 0010, 0001, 1000; done on the 4th.
